mul_reservation_station: RTL and testbench

Reservation station for the multiply functional unit of the Tomasulo core. It sits directly upstream of the 32-bit Wallace multiplier. It holds dispatched multiply instructions and snoops the common data bus (CDB) for pending source operands. When the multiplier accepts an instruction, the station hands it a pair of fully resolved 32-bit operands plus the destination tag. The multiplier's 64-bit product is written back by the downstream CDB stage; this block does not handle writeback.

---
 rtl/mul_reservation_station.sv | 136 +++++++++++++
 tb/tb_mul_reservation_station.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_reservation_station.sv
// Reservation station feeding the 32-bit multiplier: holds dispatched multiplies,
// snoops the CDB for missing operands and issues the lowest-index ready entry.
module mul_reservation_station #(
   parameter int ENTRIES = 4,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             flush,
   input  logic                             disp_valid,
   output logic                             disp_ready,
   input  logic [TAG_W-1:0]                 disp_dst,
   input  logic                             disp_j_rdy,
   input  logic [TAG_W-1:0]                 disp_qj,
   input  logic [DATA_W-1:0]                disp_vj,
   input  logic                             disp_k_rdy,
   input  logic [TAG_W-1:0]                 disp_qk,
   input  logic [DATA_W-1:0]                disp_vk,
   input  logic                             cdb_valid,
   input  logic [TAG_W-1:0]                 cdb_tag,
   input  logic [DATA_W-1:0]                cdb_data,
   output logic                             iss_valid,
   input  logic                             iss_ready,
   output logic [DATA_W-1:0]                iss_a,
   output logic [DATA_W-1:0]                iss_b,
   output logic [TAG_W-1:0]                 iss_dst,
   output logic [$clog2(ENTRIES+1)-1:0]     occupancy
);

   localparam int OCC_W = $clog2(ENTRIES + 1);
   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [ENTRIES-1:0] r_busy;
   logic [ENTRIES-1:0] r_jRdy;
   logic [ENTRIES-1:0] r_kRdy;
   logic [TAG_W-1:0]   r_qj  [ENTRIES];
   logic [TAG_W-1:0]   r_qk  [ENTRIES];
   logic [TAG_W-1:0]   r_dst [ENTRIES];
   logic [DATA_W-1:0]  r_vj  [ENTRIES];
   logic [DATA_W-1:0]  r_vk  [ENTRIES];

   logic               w_anyFree;
   logic [IDX_W-1:0]   w_freeIdx;
   logic               w_issValid;
   logic [IDX_W-1:0]   w_issIdx;
   logic [OCC_W-1:0]   w_occ;
   logic               w_dispFire;
   logic               w_issFire;
   logic               w_dispJRdy;
   logic               w_dispKRdy;
   logic [DATA_W-1:0]  w_dispVj;
   logic [DATA_W-1:0]  w_dispVk;

   // Priority encoders scan high to low so the lowest index wins.
   always_comb begin
      w_anyFree  = 1'b0;
      w_freeIdx  = '0;
      w_issValid = 1'b0;
      w_issIdx   = '0;
      w_occ      = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!r_busy[i]) begin
            w_anyFree = 1'b1;
            w_freeIdx = IDX_W'(i);
         end
         if (r_busy[i] && r_jRdy[i] && r_kRdy[i]) begin
            w_issValid = 1'b1;
            w_issIdx   = IDX_W'(i);
         end
         w_occ = w_occ + OCC_W'(r_busy[i]);
      end
   end

   always_comb begin
      w_dispFire = disp_valid && w_anyFree && !flush;
      w_issFire  = w_issValid && iss_ready && !flush;
      w_dispJRdy = disp_j_rdy || (cdb_valid && (cdb_tag == disp_qj));
      w_dispKRdy = disp_k_rdy || (cdb_valid && (cdb_tag == disp_qk));
      w_dispVj   = disp_j_rdy ? disp_vj : cdb_data;
      w_dispVk   = disp_k_rdy ? disp_vk : cdb_data;
   end

   // A dispatch target is never busy, so snoop/issue and dispatch never touch the same slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
         r_jRdy <= '0;
         r_kRdy <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_qj[i]  <= '0;
            r_qk[i]  <= '0;
            r_dst[i] <= '0;
            r_vj[i]  <= '0;
            r_vk[i]  <= '0;
         end
      end else if (flush) begin
         r_busy <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (r_busy[i]) begin
               if (cdb_valid && !r_jRdy[i] && (r_qj[i] == cdb_tag)) begin
                  r_jRdy[i] <= 1'b1;
                  r_vj[i]   <= cdb_data;
               end
               if (cdb_valid && !r_kRdy[i] && (r_qk[i] == cdb_tag)) begin
                  r_kRdy[i] <= 1'b1;
                  r_vk[i]   <= cdb_data;
               end
               if (w_issFire && (w_issIdx == IDX_W'(i))) begin
                  r_busy[i] <= 1'b0;
               end
            end else if (w_dispFire && (w_freeIdx == IDX_W'(i))) begin
               r_busy[i] <= 1'b1;
               r_dst[i]  <= disp_dst;
               r_jRdy[i] <= w_dispJRdy;
               r_qj[i]   <= disp_qj;
               r_vj[i]   <= w_dispVj;
               r_kRdy[i] <= w_dispKRdy;
               r_qk[i]   <= disp_qk;
               r_vk[i]   <= w_dispVk;
            end
         end
      end
   end

   always_comb begin
      disp_ready = w_anyFree;
      iss_valid  = w_issValid;
      occupancy  = w_occ;
      iss_a      = w_issValid ? r_vj[w_issIdx]  : '0;
      iss_b      = w_issValid ? r_vk[w_issIdx]  : '0;
      iss_dst    = w_issValid ? r_dst[w_issIdx] : '0;
   end

endmodule

// File: tb/tb_mul_reservation_station.sv
// Bench for mul_reservation_station: directed scenarios plus random traffic,
// all outputs compared every cycle against a slot-level behavioural model.
module tb_mul_reservation_station;

   localparam int ENTRIES = 4;
   localparam int DATA_W  = 32;
   localparam int TAG_W   = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic              disp_valid;
   logic              disp_ready;
   logic [TAG_W-1:0]  disp_dst;
   logic              disp_j_rdy;
   logic [TAG_W-1:0]  disp_qj;
   logic [DATA_W-1:0] disp_vj;
   logic              disp_k_rdy;
   logic [TAG_W-1:0]  disp_qk;
   logic [DATA_W-1:0] disp_vk;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic              iss_valid;
   logic              iss_ready;
   logic [DATA_W-1:0] iss_a;
   logic [DATA_W-1:0] iss_b;
   logic [TAG_W-1:0]  iss_dst;
   logic [2:0]        occupancy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_reservation_station #(.ENTRIES(ENTRIES), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_dst(disp_dst),
      .disp_j_rdy(disp_j_rdy), .disp_qj(disp_qj), .disp_vj(disp_vj),
      .disp_k_rdy(disp_k_rdy), .disp_qk(disp_qk), .disp_vk(disp_vk),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_a(iss_a), .iss_b(iss_b),
      .iss_dst(iss_dst), .occupancy(occupancy)
   );

   typedef struct {
      bit        busy;
      bit        jr;
      bit        kr;
      bit [3:0]  qj;
      bit [3:0]  qk;
      bit [3:0]  dst;
      bit [31:0] vj;
      bit [31:0] vk;
   } slot_t;

   slot_t m [ENTRIES];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int pickIssue();
      for (int i = 0; i < ENTRIES; i++)
         if (m[i].busy && m[i].jr && m[i].kr) return i;
      return -1;
   endfunction

   function automatic int pickFree();
      for (int i = 0; i < ENTRIES; i++)
         if (!m[i].busy) return i;
      return -1;
   endfunction

   function automatic int modelOcc();
      int n = 0;
      for (int i = 0; i < ENTRIES; i++) n += m[i].busy;
      return n;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < ENTRIES; i++) m[i] = '{default: 0};
   endtask

   task automatic compareModel();
      int s = pickIssue();
      int occ = modelOcc();
      checkOutput("occupancy", occupancy, occ);
      checkOutput("disp_ready", disp_ready, occ < ENTRIES);
      checkOutput("iss_valid", iss_valid, s >= 0);
      checkOutput("iss_a", iss_a, (s >= 0) ? m[s].vj : 32'h0);
      checkOutput("iss_b", iss_b, (s >= 0) ? m[s].vk : 32'h0);
      checkOutput("iss_dst", iss_dst, (s >= 0) ? m[s].dst : 4'h0);
   endtask

   // Next-state of the model for one clock edge, from the rules of the station.
   task automatic modelEdge();
      slot_t nxt [ENTRIES];
      int s = pickIssue();
      int f = pickFree();
      if (flush) begin
         for (int i = 0; i < ENTRIES; i++) m[i].busy = 0;
         return;
      end
      nxt = m;
      for (int i = 0; i < ENTRIES; i++) begin
         if (m[i].busy && cdb_valid) begin
            if (!m[i].jr && m[i].qj == cdb_tag) begin nxt[i].jr = 1; nxt[i].vj = cdb_data; end
            if (!m[i].kr && m[i].qk == cdb_tag) begin nxt[i].kr = 1; nxt[i].vk = cdb_data; end
         end
      end
      if (s >= 0 && iss_ready) nxt[s].busy = 0;
      if (disp_valid && f >= 0) begin
         nxt[f].busy = 1;
         nxt[f].dst  = disp_dst;
         nxt[f].qj   = disp_qj;
         nxt[f].qk   = disp_qk;
         nxt[f].jr   = disp_j_rdy || (cdb_valid && cdb_tag == disp_qj);
         nxt[f].kr   = disp_k_rdy || (cdb_valid && cdb_tag == disp_qk);
         nxt[f].vj   = disp_j_rdy ? disp_vj : cdb_data;
         nxt[f].vk   = disp_k_rdy ? disp_vk : cdb_data;
      end
      m = nxt;
   endtask

   task automatic clearInputs();
      flush = 0; disp_valid = 0; disp_dst = 0;
      disp_j_rdy = 0; disp_qj = 0; disp_vj = 0;
      disp_k_rdy = 0; disp_qk = 0; disp_vk = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
      iss_ready = 0;
   endtask

   task automatic setDispatch(input logic [3:0] dst, input logic jr, input logic [3:0] qj, input logic [31:0] vj,
                              input logic kr, input logic [3:0] qk, input logic [31:0] vk);
      disp_valid = 1; disp_dst = dst;
      disp_j_rdy = jr; disp_qj = qj; disp_vj = vj;
      disp_k_rdy = kr; disp_qk = qk; disp_vk = vk;
   endtask

   // Called just after a negedge with inputs set: check, clock, advance the model.
   task automatic applyStimulus();
      #1;
      compareModel();
      @(posedge clk);
      modelEdge();
      @(negedge clk);
   endtask

   initial begin
      clearInputs();
      rst_n = 0;
      modelReset();
      repeat (2) @(negedge clk);
      rst_n = 1;

      checkOutput("rst_disp_ready", disp_ready, 1);
      checkOutput("rst_iss_valid", iss_valid, 0);
      checkOutput("rst_occupancy", occupancy, 0);

      // Both operands ready at dispatch
      setDispatch(4'd3, 1, 4'd0, 32'h00e00003, 1, 4'd0, 32'h0000a000);
      iss_ready = 1;
      applyStimulus();
      clearInputs(); iss_ready = 1;
      checkOutput("s1_iss_valid", iss_valid, 1);
      checkOutput("s1_iss_a", iss_a, 32'h00e00003);
      checkOutput("s1_iss_b", iss_b, 32'h0000a000);
      checkOutput("s1_iss_dst", iss_dst, 3);
      applyStimulus();
      checkOutput("s1_occ_after", occupancy, 0);

      // K waits on tag 7, broadcast two cycles later
      clearInputs();
      setDispatch(4'd5, 1, 4'd0, 32'h0000FFFF, 0, 4'd7, 32'h0);
      applyStimulus();
      clearInputs();
      applyStimulus();
      checkOutput("s2_wait_valid", iss_valid, 0);
      cdb_valid = 1; cdb_tag = 4'd7; cdb_data = 32'h0000FFFF;
      applyStimulus();
      clearInputs(); iss_ready = 1;
      checkOutput("s2_iss_valid", iss_valid, 1);
      checkOutput("s2_iss_b", iss_b, 32'h0000FFFF);
      checkOutput("s2_iss_dst", iss_dst, 5);
      applyStimulus();

      // Forwarding at dispatch
      clearInputs();
      setDispatch(4'd6, 1, 4'd0, 32'h2, 0, 4'd9, 32'h0);
      cdb_valid = 1; cdb_tag = 4'd9; cdb_data = 32'h00001234;
      applyStimulus();
      clearInputs(); iss_ready = 1;
      checkOutput("s3_iss_valid", iss_valid, 1);
      checkOutput("s3_iss_b", iss_b, 32'h00001234);
      applyStimulus();

      // Fill, reject fifth, then drain in order
      for (int k = 0; k < 4; k++) begin
         clearInputs();
         setDispatch(4'(k), 1, 4'd0, 32'h100 + k, 1, 4'd0, 32'h200 + k);
         applyStimulus();
      end
      clearInputs();
      checkOutput("s4_full_ready", disp_ready, 0);
      checkOutput("s4_full_occ", occupancy, 4);
      setDispatch(4'hF, 1, 4'd0, 32'hDEAD, 1, 4'd0, 32'hBEEF);
      applyStimulus();
      clearInputs(); iss_ready = 1;
      for (int k = 0; k < 4; k++) begin
         checkOutput("s4_drain_dst", iss_dst, k);
         checkOutput("s4_drain_a", iss_a, 32'h100 + k);
         applyStimulus();
      end
      checkOutput("s4_empty_occ", occupancy, 0);

      // Pre-emption of a stalled presentation by a lower slot
      clearInputs();
      setDispatch(4'd8, 0, 4'hA, 32'h0, 1, 4'd0, 32'h88);
      applyStimulus();
      clearInputs();
      setDispatch(4'd9, 0, 4'hB, 32'h0, 1, 4'd0, 32'h99);
      applyStimulus();
      clearInputs();
      setDispatch(4'd2, 1, 4'd0, 32'h22, 1, 4'd0, 32'h23);
      applyStimulus();
      clearInputs();
      checkOutput("s5_present2", iss_dst, 2);
      applyStimulus();
      checkOutput("s5_hold2", iss_dst, 2);
      cdb_valid = 1; cdb_tag = 4'hA; cdb_data = 32'h11;
      applyStimulus();
      clearInputs(); iss_ready = 1;
      checkOutput("s5_preempt_dst", iss_dst, 8);
      checkOutput("s5_preempt_a", iss_a, 32'h11);
      applyStimulus();
      checkOutput("s5_then2", iss_dst, 2);
      applyStimulus();
      checkOutput("s5_left_occ", occupancy, 1);

      // Flush with concurrent dispatch
      clearInputs();
      setDispatch(4'd1, 0, 4'hC, 32'h0, 1, 4'd0, 32'h1);
      applyStimulus();
      applyStimulus();
      clearInputs();
      checkOutput("s6_occ3", occupancy, 3);
      flush = 1; iss_ready = 1;
      setDispatch(4'd4, 1, 4'd0, 32'h4, 1, 4'd0, 32'h4);
      applyStimulus();
      clearInputs();
      checkOutput("s6_flush_occ", occupancy, 0);
      checkOutput("s6_flush_valid", iss_valid, 0);

      // Asynchronous reset mid-cycle
      setDispatch(4'd7, 1, 4'd0, 32'h77, 1, 4'd0, 32'h78);
      applyStimulus();
      clearInputs();
      checkOutput("s7_pre_valid", iss_valid, 1);
      #2 rst_n = 0;
      #1;
      checkOutput("s7_rst_valid", iss_valid, 0);
      checkOutput("s7_rst_occ", occupancy, 0);
      modelReset();
      @(negedge clk);
      rst_n = 1;

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         clearInputs();
         if ($urandom_range(0, 9) < 6)
            setDispatch(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom(),
                        1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom());
         cdb_valid = 1'($urandom_range(0, 1));
         cdb_tag   = 4'($urandom_range(0, 7));
         cdb_data  = $urandom();
         iss_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 49) == 0);
         applyStimulus();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
